// File: rtl/nano_loader.sv
`default_nettype none
// ============================================================================
// Module      : nano_loader
// Description : Streams a program image into memory, verifies its XOR checksum,
//               then releases the CPU and hands it the memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module nano_loader #(
    parameter logic [7:0] START_ADDR = 8'h00
) (
    input  logic        ck,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [7:0]  cpu_address,
    input  logic [15:0] cpu_dataW,
    input  logic        cpu_ce,
    input  logic        cpu_we,
    output logic [7:0]  mem_address,
    output logic [15:0] mem_dataW,
    output logic        mem_ce,
    output logic        mem_we,
    output logic        cpu_rst,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_CNT = 3'd0,
        S_HI  = 3'd1,
        S_LO  = 3'd2,
        S_WR  = 3'd3,
        S_CHK = 3'd4,
        S_RUN = 3'd5,
        S_ERR = 3'd6
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] n_q, n_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] hi_q, hi_d;
    logic [7:0] lo_q, lo_d;
    logic [7:0] csum_q, csum_d;
    logic       cpu_rst_q, cpu_rst_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       xfer;

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        idx_d       = idx_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        csum_d      = csum_q;
        rx_ready    = 1'b0;
        mem_address = 8'h00;
        mem_dataW   = 16'h0000;
        mem_ce      = 1'b0;
        mem_we      = 1'b0;

        case (state_q)
            S_CNT, S_HI, S_LO, S_CHK: rx_ready = 1'b1;
            default:                  rx_ready = 1'b0;
        endcase
        xfer = rx_valid & rx_ready;

        case (state_q)
            S_CNT: begin
                if (xfer) begin
                    n_d     = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    idx_d   = 8'h00;
                    state_d = (rx_data == 8'h00) ? S_CHK : S_HI;
                end
            end
            S_HI: begin
                if (xfer) begin
                    hi_d    = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (xfer) begin
                    lo_d    = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                // Address arithmetic is 8-bit, so it wraps past 8'hFF naturally.
                mem_ce      = 1'b1;
                mem_we      = 1'b1;
                mem_address = START_ADDR + idx_q;
                mem_dataW   = {hi_q, lo_q};
                idx_d       = idx_q + 8'd1;
                state_d     = (idx_d == n_q) ? S_CHK : S_HI;
            end
            S_CHK: begin
                if (xfer) begin
                    state_d = (rx_data == csum_q) ? S_RUN : S_ERR;
                end
            end
            S_RUN: begin
                mem_address = cpu_address;
                mem_dataW   = cpu_dataW;
                mem_ce      = cpu_ce;
                mem_we      = cpu_we;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase

        // Decoding the next state lets cpu_rst drop on the very edge that enters RUN.
        cpu_rst_d = (state_d != S_RUN);
        done_d    = (state_d == S_RUN);
        err_d     = (state_d == S_ERR);
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state_q   <= S_CNT;
            n_q       <= 8'h00;
            idx_q     <= 8'h00;
            hi_q      <= 8'h00;
            lo_q      <= 8'h00;
            csum_q    <= 8'h00;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            csum_q    <= csum_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign cpu_rst = cpu_rst_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule
`default_nettype wire
